// File: rtl/counter_event_monitor.sv
// Watches an upstream counter's count value and queues wrap, threshold-arrival and
// discontinuity events in a 4-deep first-word fall-through FIFO with valid/ready drain.
module counter_event_monitor #(
  parameter int Size      = 5,
  parameter int Threshold = 20,
  parameter int WrapWidth = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [Size-1:0]      count,
  input  logic                 event_ready,
  output logic                 event_valid,
  output logic [2:0]           event_type,
  output logic [Size-1:0]      event_count,
  output logic [WrapWidth-1:0] event_wraps,
  output logic [WrapWidth-1:0] wraps,
  output logic                 overflow
);

  localparam logic [Size-1:0] ThreshVal = Size'(Threshold);
  localparam logic [Size-1:0] MaxVal    = '1;

  logic [Size-1:0]      prev_reg;
  logic                 prev_valid_reg;
  logic [WrapWidth-1:0] wraps_reg;
  logic [WrapWidth-1:0] wraps_next;
  logic [1:0]           wr_ptr_reg;
  logic [1:0]           rd_ptr_reg;
  logic [2:0]           occ_reg;
  logic                 overflow_reg;

  logic [2:0]           type_mem  [4];
  logic [Size-1:0]      count_mem [4];
  logic [WrapWidth-1:0] wraps_mem [4];

  logic [Size-1:0] prev_inc;
  logic            wrap_hit;
  logic            thresh_hit;
  logic            disc_hit;
  logic [2:0]      flags;
  logic            push;
  logic            pop;
  logic            full;
  logic            push_en;
  logic            drop;

  assign prev_inc   = prev_reg + Size'(1);
  assign wrap_hit   = prev_valid_reg && (prev_reg == MaxVal) && (count == '0);
  assign thresh_hit = (count == ThreshVal) && (!prev_valid_reg || (prev_reg != ThreshVal));
  assign disc_hit   = prev_valid_reg && (count != prev_reg) && (count != prev_inc);
  assign flags      = {disc_hit, thresh_hit, wrap_hit};

  assign wraps_next = wraps_reg + WrapWidth'(wrap_hit);

  assign push    = |flags;
  assign pop     = event_valid && event_ready;
  assign full    = (occ_reg == 3'd4);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_en = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
      wraps_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      occ_reg        <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      prev_reg       <= count;
      prev_valid_reg <= 1'b1;
      wraps_reg      <= wraps_next;
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 2'd1;
      occ_reg <= occ_reg + 3'(push_en) - 3'(pop);
      if (drop) overflow_reg <= 1'b1;
    end
  end

  // Storage needs no reset: the head outputs are masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (!reset && push_en) begin
      type_mem[wr_ptr_reg]  <= flags;
      count_mem[wr_ptr_reg] <= count;
      wraps_mem[wr_ptr_reg] <= wraps_next;
    end
  end

  assign event_valid = (occ_reg != 3'd0);
  assign event_type  = event_valid ? type_mem[rd_ptr_reg]  : '0;
  assign event_count = event_valid ? count_mem[rd_ptr_reg] : '0;
  assign event_wraps = event_valid ? wraps_mem[rd_ptr_reg] : '0;
  assign wraps       = wraps_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_counter_event_monitor.sv
// Directed bench for counter_event_monitor (Size=5, Threshold=20, WrapWidth=8).
module tb_counter_event_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] count = '0;
  logic       event_ready = 1'b1;
  logic       event_valid;
  logic [2:0] event_type;
  logic [4:0] event_count;
  logic [7:0] event_wraps;
  logic [7:0] wraps;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  counter_event_monitor #(.Size(5), .Threshold(20), .WrapWidth(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .count       (count),
    .event_ready (event_ready),
    .event_valid (event_valid),
    .event_type  (event_type),
    .event_count (event_count),
    .event_wraps (event_wraps),
    .wraps       (wraps),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [4:0] c);
    count = c;
    @(posedge clock);
    #1;
    $display("edge t=%0t count=%0d valid=%0b type=%03b ecount=%0d ewraps=%0d wraps=%0d ovf=%0b",
             $time, c, event_valid, event_type, event_count, event_wraps, wraps, overflow);
  endtask

  task automatic do_reset(input logic [4:0] c);
    reset = 1'b1;
    step(c);
    reset = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [2:0] t, input logic [4:0] c,
                            input logic [7:0] w);
    check({tag, "_valid"}, 32'(event_valid), 32'd1);
    check({tag, "_type"},  32'(event_type),  32'(t));
    check({tag, "_count"}, 32'(event_count), 32'(c));
    check({tag, "_ewraps"}, 32'(event_wraps), 32'(w));
  endtask

  initial begin
    // Test 1: reset, then a clean 0..31,0 sweep with the consumer always ready.
    event_ready = 1'b1;
    do_reset(5'd0);
    do_reset(5'd0);
    check("rst_valid",  32'(event_valid), 32'd0);
    check("rst_type",   32'(event_type),  32'd0);
    check("rst_count",  32'(event_count), 32'd0);
    check("rst_ewraps", 32'(event_wraps), 32'd0);
    check("rst_wraps",  32'(wraps),       32'd0);
    check("rst_ovf",    32'(overflow),    32'd0);
    for (int c = 0; c < 32; c++) begin
      step(5'(c));
      if (c == 20) check_head("t1_thresh", 3'b010, 5'd20, 8'd0);
      else         check("t1_idle", 32'(event_valid), 32'd0);
    end
    step(5'd0);
    check_head("t1_wrap", 3'b001, 5'd0, 8'd1);
    check("t1_wraps", 32'(wraps), 32'd1);

    // Test 2: arrive at 20 from 19 and hold; exactly one threshold event.
    for (int c = 1; c < 20; c++) begin
      step(5'(c));
      check("t2_idle", 32'(event_valid), 32'd0);
    end
    step(5'd20);
    check_head("t2_thresh", 3'b010, 5'd20, 8'd1);
    step(5'd20);
    check("t2_hold1", 32'(event_valid), 32'd0);
    step(5'd20);
    check("t2_hold2", 32'(event_valid), 32'd0);

    // Test 3: back-to-back discontinuities 20->7->3, then hold at 3.
    step(5'd7);
    check_head("t3_disc7", 3'b100, 5'd7, 8'd1);
    step(5'd3);
    check_head("t3_disc3", 3'b100, 5'd3, 8'd1);
    step(5'd3);
    check("t3_hold", 32'(event_valid), 32'd0);

    // Test 4: five events with the consumer stalled; the fifth is dropped.
    step(5'd1);
    step(5'd1);
    check("t4_empty", 32'(event_valid), 32'd0);
    event_ready = 1'b0;
    step(5'd5);
    step(5'd9);
    step(5'd13);
    step(5'd17);
    check("t4_ovf_before", 32'(overflow), 32'd0);
    step(5'd22);
    check("t4_ovf_after", 32'(overflow), 32'd1);
    check_head("t4_head5", 3'b100, 5'd5, 8'd1);
    event_ready = 1'b1;
    step(5'd22);
    check_head("t4_head9", 3'b100, 5'd9, 8'd1);
    step(5'd22);
    check_head("t4_head13", 3'b100, 5'd13, 8'd1);
    step(5'd22);
    check_head("t4_head17", 3'b100, 5'd17, 8'd1);
    step(5'd22);
    check("t4_drained", 32'(event_valid), 32'd0);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);

    // Test 5: full FIFO with push and pop on the same edge.
    event_ready = 1'b0;
    do_reset(5'd0);
    check("t5_ovf_rst", 32'(overflow), 32'd0);
    step(5'd0);
    step(5'd5);
    step(5'd9);
    step(5'd13);
    step(5'd17);
    event_ready = 1'b1;
    step(5'd22);
    check("t5_ovf_pushpop", 32'(overflow), 32'd0);
    check_head("t5_head9", 3'b100, 5'd9, 8'd0);
    event_ready = 1'b0;
    step(5'd26);
    check("t5_still_full", 32'(overflow), 32'd1);
    event_ready = 1'b1;
    step(5'd26);
    check_head("t5_head13", 3'b100, 5'd13, 8'd0);
    step(5'd26);
    check_head("t5_head17", 3'b100, 5'd17, 8'd0);
    step(5'd26);
    check_head("t5_head22", 3'b100, 5'd22, 8'd0);
    step(5'd26);
    check("t5_drained", 32'(event_valid), 32'd0);

    // Test 6: reset with three events queued and two wraps counted.
    step(5'd31);
    step(5'd31);
    check("t6_empty", 32'(event_valid), 32'd0);
    event_ready = 1'b0;
    step(5'd0);
    step(5'd31);
    step(5'd0);
    check("t6_wraps2", 32'(wraps), 32'd2);
    check_head("t6_head", 3'b001, 5'd0, 8'd1);
    event_ready = 1'b1;
    do_reset(5'd31);
    check("t6_rst_valid", 32'(event_valid), 32'd0);
    check("t6_rst_wraps", 32'(wraps),       32'd0);
    check("t6_rst_ovf",   32'(overflow),    32'd0);
    check("t6_rst_type",  32'(event_type),  32'd0);
    step(5'd0);
    check("t6_nowrap_valid", 32'(event_valid), 32'd0);
    check("t6_nowrap_wraps", 32'(wraps),       32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
